// File: rtl/adventure_game_fsm.sv
// adventure_game_fsm
// Text-adventure controller for the lab board. A room FSM walks a seven-room
// map one compass move per clock, and a one-bit sword flag records whether the
// player has visited the Secret Sword Stash. Entering the Dragon's Den resolves
// on the following edge to either the Victory Vault (sword held) or the
// Grievous Graveyard (no sword). Both end rooms are held until reset.
// Room indicators come straight from the one-hot state register, so every
// output is registered and changes only on a clock edge or on reset.

module adventure_game_fsm (
   input  logic clk,
   input  logic reset,
   input  logic n,
   input  logic s,
   input  logic e,
   input  logic w,
   output logic win,
   output logic d,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic s4,
   output logic s5,
   output logic s6
);

   // One-hot room encoding: bit k drives LED sk directly.
   typedef enum logic [6:0] {
      CAVE   = 7'b000_0001,
      TUNNEL = 7'b000_0010,
      RIVER  = 7'b000_0100,
      STASH  = 7'b000_1000,
      DEN    = 7'b001_0000,
      GRAVE  = 7'b010_0000,
      VAULT  = 7'b100_0000
   } room_t;

   // Only the highest-priority asserted direction is ever acted upon.
   typedef enum logic [2:0] {
      MV_NONE,
      MV_N,
      MV_S,
      MV_E,
      MV_W
   } move_t;

   room_t       room;
   logic        sword;
   move_t       move;
   logic [6:0]  room_bits;

   // Resolve simultaneous direction inputs with priority n > s > e > w.
   always_comb begin
      move = MV_NONE;
      if (n)      move = MV_N;
      else if (s) move = MV_S;
      else if (e) move = MV_E;
      else if (w) move = MV_W;
   end

   // Room and sword state; the sword is latched on any edge spent in the Stash.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         room  <= CAVE;
         sword <= 1'b0;
      end else begin
         if (room == STASH) begin
            sword <= 1'b1;
         end
         case (room)
            CAVE: begin
               if (move == MV_E) room <= TUNNEL;
            end
            TUNNEL: begin
               if (move == MV_W)      room <= CAVE;
               else if (move == MV_S) room <= RIVER;
            end
            RIVER: begin
               if (move == MV_N)      room <= TUNNEL;
               else if (move == MV_W) room <= STASH;
               else if (move == MV_E) room <= DEN;
            end
            STASH: begin
               if (move == MV_E) room <= RIVER;
            end
            // Den ignores directions; the outcome depends only on the sword.
            DEN: begin
               room <= sword ? VAULT : GRAVE;
            end
            GRAVE: room <= GRAVE;
            VAULT: room <= VAULT;
            // An illegal encoding can only arise from upset; restart the game.
            default: room <= CAVE;
         endcase
      end
   end

   assign room_bits = room;

   // Room indicators are the state bits; win/dead are decoded from the room only.
   always_comb begin
      s0  = room_bits[0];
      s1  = room_bits[1];
      s2  = room_bits[2];
      s3  = room_bits[3];
      s4  = room_bits[4];
      s5  = room_bits[5];
      s6  = room_bits[6];
      win = room_bits[6];
      d   = room_bits[5];
   end

endmodule

// File: tb/tb_adventure_game_fsm.sv
// Testbench for adventure_game_fsm. Stimulus drives one move per cycle and
// pushes the hand-chosen expected room into a scoreboard queue; an independent
// monitor pops an entry after each rising clock or reset edge and compares the
// full output vector {win, d, s6..s0}.

module tb_adventure_game_fsm;

   logic clk;
   logic reset;
   logic n, s, e, w;
   logic win, d, s0, s1, s2, s3, s4, s5, s6;

   typedef struct {
      string      name;
      logic [8:0] exp;
   } item_t;

   item_t q[$];
   int    checks = 0;
   int    fails  = 0;

   adventure_game_fsm dut (
      .clk   (clk),
      .reset (reset),
      .n     (n),
      .s     (s),
      .e     (e),
      .w     (w),
      .win   (win),
      .d     (d),
      .s0    (s0),
      .s1    (s1),
      .s2    (s2),
      .s3    (s3),
      .s4    (s4),
      .s5    (s5),
      .s6    (s6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output vector for room index r (0=Cave .. 6=Vault).
   function automatic logic [8:0] room_vec(input int r);
      logic [6:0] oh;
      oh = 7'b1 << r;
      return {(r == 6), (r == 5), oh};
   endfunction

   // Monitor: after every clock or reset edge, check the next queued expectation.
   initial begin
      item_t      it;
      logic [8:0] act;
      forever begin
         @(posedge clk or posedge reset);
         #1;
         if (q.size() > 0) begin
            it  = q.pop_front();
            act = {win, d, s6, s5, s4, s3, s2, s1, s0};
            checks++;
            if (act !== it.exp) begin
               fails++;
               $display("FAIL %s: got %b, expected %b (win,d,s6..s0)", it.name, act, it.exp);
            end
         end
      end
   end

   // Drive one move for the next edge and queue the room expected after it.
   task automatic step(input string name, input logic [3:0] nsew, input int room);
      @(negedge clk);
      {n, s, e, w} = nsew;
      q.push_back('{name, room_vec(room)});
   endtask

   // Assert reset between edges; Cave is expected immediately, then release.
   task automatic do_reset(input string name);
      @(negedge clk);
      {n, s, e, w} = 4'b0000;
      #2;
      q.push_back('{name, room_vec(0)});
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   localparam logic [3:0] NONE = 4'b0000;
   localparam logic [3:0] N    = 4'b1000;
   localparam logic [3:0] S    = 4'b0100;
   localparam logic [3:0] E    = 4'b0010;
   localparam logic [3:0] W    = 4'b0001;

   initial begin
      int budget;
      reset = 1'b0;
      {n, s, e, w} = 4'b0000;
      repeat (2) @(negedge clk);

      // Reset then idle
      do_reset("reset_initial");
      step("idle1", NONE, 0);
      step("idle2", NONE, 0);
      step("idle3", NONE, 0);
      step("cave_w_invalid", W, 0);
      step("cave_all_n_wins", N | S | E | W, 0);

      // Death path
      step("death_e", E, 1);
      step("death_s", S, 2);
      step("death_e_den", E, 4);
      step("death_grave", NONE, 5);
      step("grave_hold_e", E, 5);
      step("grave_hold_n", N, 5);
      step("grave_hold_w", W, 5);
      do_reset("reset_from_grave");

      // Win path
      step("win_e", E, 1);
      step("win_s", S, 2);
      step("win_w_stash", W, 3);
      step("stash_s_invalid", S, 3);
      step("win_e_river", E, 2);
      step("win_e_den", E, 4);
      step("win_vault", W, 6);
      step("vault_hold_s", S, 6);
      do_reset("reset_from_vault");

      // Priority and backtracking
      step("bt_e", E, 1);
      step("tunnel_ns_stay", N | S, 1);
      step("tunnel_s", S, 2);
      step("river_ne_north", N | E, 1);
      step("tunnel_s2", S, 2);
      step("river_w", W, 3);
      step("stash_e", E, 2);
      step("river_n", N, 1);
      step("tunnel_w_cave", W, 0);
      step("cave_e", E, 1);
      step("tunnel_we_s_none", W, 0);

      // Collect sword, then reset mid-game: sword must be gone
      step("sw_e", E, 1);
      step("sw_s", S, 2);
      step("sw_w", W, 3);
      step("sw_e_river", E, 2);
      do_reset("reset_mid_game");
      step("post_e", E, 1);
      step("post_s", S, 2);
      step("post_e_den", E, 4);
      step("post_grave", NONE, 5);
      step("post_grave_hold", NONE, 5);

      // Drain the scoreboard within a bounded number of cycles
      budget = 20;
      while (q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (q.size() > 0) begin
         checks++;
         fails++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
